// File: rtl/mem_responder_if.sv
// CPU-side bus of mem_responder: request strobe, rw, word address and write data in;
// registered read data, completion pulse and status flags out.
interface mem_responder_if;
   logic        req;
   logic        rw;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ready;
   logic        busy;
   logic        fault;

   modport master (output req, rw, address, data_in, input data_out, ready, busy, fault);
   modport slave  (input req, rw, address, data_in, output data_out, ready, busy, fault);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed single-port RAM responder with programmable wait states and a one-cycle ready pulse.
// Define MEM_RANGE_CHECK_EN to suppress and flag (fault) accesses whose address exceeds the depth.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic            clock,
   input logic            reset,
   mem_responder_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   localparam bit         NO_WAIT   = (WAIT_STATES == 0);
   localparam logic [2:0] WAIT_INIT = NO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

   state_t                state;
   state_t                next_state;
   logic [2:0]            wait_cnt;
   logic                  req_rw;
   logic [31:0]           req_addr;
   logic [31:0]           req_data;
   logic [31:0]           rd_data;
   logic [DEPTH_LOG2-1:0] index;
   logic                  in_range;
   logic                  accept;
   logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];

   assign index  = req_addr[DEPTH_LOG2-1:0];
   assign accept = bus.req && ((state == S_IDLE) || (state == S_RESP));

`ifdef MEM_RANGE_CHECK_EN
   logic fault_q;
   assign in_range = ~|req_addr[31:DEPTH_LOG2];
`else
   logic unused_addr_hi;
   assign in_range       = 1'b1;
   assign unused_addr_hi = |req_addr[31:DEPTH_LOG2];
`endif

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_RESP: next_state = bus.req ? (NO_WAIT ? S_ACCESS : S_WAIT) : S_IDLE;
         S_WAIT:         if (wait_cnt == '0) next_state = S_ACCESS;
         S_ACCESS:       next_state = S_RESP;
         default:        next_state = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready    = (state == S_RESP);
      bus.busy     = (state == S_WAIT) || (state == S_ACCESS);
      bus.data_out = rd_data;
`ifdef MEM_RANGE_CHECK_EN
      bus.fault    = (state == S_RESP) && fault_q;
`else
      bus.fault    = 1'b0;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wait_cnt <= '0;
         req_rw   <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         rd_data  <= '0;
      end else begin
         if (accept) begin
            req_rw   <= bus.rw;
            req_addr <= bus.address;
            req_data <= bus.data_in;
            wait_cnt <= WAIT_INIT;
         end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if ((state == S_ACCESS) && req_rw) rd_data <= in_range ? mem[index] : '0;
      end
   end

`ifdef MEM_RANGE_CHECK_EN
   always_ff @(posedge clock) begin
      if (!reset)                 fault_q <= 1'b0;
      else if (state == S_ACCESS) fault_q <= !in_range;
   end
`endif

   // Gated by reset so a write whose ACCESS edge meets reset is dropped; contents are never cleared.
   always_ff @(posedge clock) begin
      if (reset && (state == S_ACCESS) && !req_rw && in_range) mem[index] <= req_data;
   end
endmodule
